// File: rtl/minsoc_clock_pkg.sv
// Shared definitions for the divided-clock monitor.
// The divider and the monitor both derive EXP from these functions.
package minsoc_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } mon_state_e;

    // Odd divisors round down, matching the generic divider's output period.
    function automatic int unsigned clk_exp(input int unsigned div);
        return 2 * (div / 2);
    endfunction

    function automatic int unsigned clk_timeout(input int unsigned div);
        return 4 * clk_exp(div);
    endfunction

endpackage

// File: rtl/minsoc_sync_edge.sv
// Two-flop synchronizer plus delay flop with a rising-edge pulse.
// Reusable for any asynchronous status level.
module minsoc_sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/minsoc_clock_monitor.sv
// Measures the period of a divided clock in clk_i cycles and
// reports lock, loss of clock and a saturating error count.
module minsoc_clock_monitor
    import minsoc_clock_pkg::*;
#(
    parameter int unsigned divisor    = 4,
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned TOL        = 0,
    parameter int unsigned PERIOD_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                mon_clk_i,
    output logic                locked_o,
    output logic                lost_o,
    output logic [PERIOD_W-1:0] period_o,
    output logic                period_valid_o,
    output logic [7:0]          err_cnt_o
);

    localparam logic [PERIOD_W-1:0] EXP_V = PERIOD_W'(clk_exp(divisor));
    localparam logic [PERIOD_W-1:0] TMO_V = PERIOD_W'(clk_timeout(divisor));
    localparam logic [PERIOD_W-1:0] TOL_V = PERIOD_W'(TOL);
    localparam logic [7:0]          LC_V  = 8'(LOCK_COUNT);

    mon_state_e          r_state;
    logic [PERIOD_W-1:0] r_cnt;
    logic [PERIOD_W-1:0] r_period;
    logic                r_pvalid;
    logic [7:0]          r_good;
    logic [7:0]          r_err;

    logic                w_edge;
    logic [PERIOD_W-1:0] w_diff;
    logic                w_match;
    logic                w_timeout;
    logic [7:0]          w_good_inc;
    logic [7:0]          w_err_inc;
    logic [PERIOD_W-1:0] w_cnt_nxt;

    minsoc_sync_edge u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_async (mon_clk_i),
        .o_rise  (w_edge)
    );

    // Order the operands first so the distance never underflows.
    assign w_diff  = (r_cnt >= EXP_V) ? (r_cnt - EXP_V) : (EXP_V - r_cnt);
    assign w_match = (w_diff <= TOL_V);

    assign w_good_inc = (r_good >= LC_V) ? r_good : r_good + 8'd1;
    assign w_err_inc  = (&r_err) ? r_err : r_err + 8'd1;
    assign w_cnt_nxt  = (&r_cnt) ? r_cnt : r_cnt + PERIOD_W'(1);

    // An edge landing on the timeout cycle wins over the timeout.
    assign w_timeout = (r_cnt == TMO_V) && !w_edge && (r_state != ST_LOST);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_pvalid <= 1'b0;
            r_good   <= '0;
            r_err    <= '0;
        end else begin
            r_pvalid <= 1'b0;
            r_cnt    <= w_edge ? PERIOD_W'(1) : w_cnt_nxt;
            if (w_edge) begin
                unique case (r_state)
                    ST_IDLE, ST_LOST: begin
                        r_state <= ST_MEASURE;
                    end
                    ST_MEASURE, ST_LOCKED: begin
                        r_period <= r_cnt;
                        r_pvalid <= 1'b1;
                        if (w_match) begin
                            r_good <= w_good_inc;
                            if (w_good_inc == LC_V)
                                r_state <= ST_LOCKED;
                        end else begin
                            r_good  <= '0;
                            r_err   <= w_err_inc;
                            r_state <= ST_MEASURE;
                        end
                    end
                endcase
            end else if (w_timeout) begin
                r_state <= ST_LOST;
                r_good  <= '0;
                r_err   <= w_err_inc;
            end
        end
    end

    assign locked_o       = (r_state == ST_LOCKED);
    assign lost_o         = (r_state == ST_LOST);
    assign period_o       = r_period;
    assign period_valid_o = r_pvalid;
    assign err_cnt_o      = r_err;

endmodule

// File: tb/tb_minsoc_clock_monitor.sv
// Bench for minsoc_clock_monitor: two instances (TOL 0 and 1)
// share stimulus and are checked against an edge-timestamp model.
module tb_minsoc_clock_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mon = 1'b0;

    logic        lk0, ls0, pv0, lk1, ls1, pv1;
    logic [15:0] per0, per1;
    logic [7:0]  err0, err1;

    always #5 clk = ~clk;

    minsoc_clock_monitor #(
        .divisor(4), .LOCK_COUNT(8), .TOL(0), .PERIOD_W(16)
    ) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .mon_clk_i(mon),
        .locked_o(lk0), .lost_o(ls0), .period_o(per0),
        .period_valid_o(pv0), .err_cnt_o(err0)
    );

    minsoc_clock_monitor #(
        .divisor(4), .LOCK_COUNT(8), .TOL(1), .PERIOD_W(16)
    ) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .mon_clk_i(mon),
        .locked_o(lk1), .lost_o(ls1), .period_o(per1),
        .period_valid_o(pv1), .err_cnt_o(err1)
    );

    localparam int EXP = 4;
    localparam int TMO = 16;
    localparam int LC  = 8;

    int total = 0;
    int bad   = 0;

    // Reference model: periods are differences of edge timestamps.
    int   cyc = 0;
    int   last_edge = 0;
    logic [2:0] hist = '0;
    int   tol [2] = '{0, 1};
    bit   m_active [2];
    bit   m_locked [2];
    bit   m_lost [2];
    bit   m_pv [2];
    int   m_good [2];
    int   m_err [2];
    int   m_per [2];
    bit   chk_en = 0;
    bit   saw_lost = 0;
    int   pv_max = 0;

    task automatic model_step(input logic r, input logic m);
        bit e;
        int cnt;
        int d;
        if (!r) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i] = 0; m_locked[i] = 0; m_lost[i] = 0;
                m_pv[i] = 0; m_good[i] = 0; m_err[i] = 0; m_per[i] = 0;
            end
            last_edge = cyc + 1;
            hist = '0;
        end else begin
            e   = hist[1] && !hist[2];
            cnt = cyc - last_edge;
            if (cnt > 65535) cnt = 65535;
            for (int i = 0; i < 2; i++) begin
                m_pv[i] = 0;
                if (e) begin
                    if (m_active[i]) begin
                        m_per[i] = cnt;
                        m_pv[i]  = 1;
                        d = (cnt > EXP) ? cnt - EXP : EXP - cnt;
                        if (d <= tol[i]) begin
                            if (m_good[i] < LC) m_good[i]++;
                            if (m_good[i] == LC) m_locked[i] = 1;
                        end else begin
                            m_good[i] = 0;
                            m_locked[i] = 0;
                            if (m_err[i] < 255) m_err[i]++;
                        end
                    end else begin
                        m_active[i] = 1;
                        m_lost[i] = 0;
                    end
                end else if (cnt == TMO && !m_lost[i]) begin
                    m_lost[i] = 1; m_active[i] = 0; m_locked[i] = 0;
                    m_good[i] = 0;
                    if (m_err[i] < 255) m_err[i]++;
                end
            end
            if (e) last_edge = cyc;
            hist = {hist[1:0], m};
        end
        cyc++;
    endtask

    task automatic check_out();
        logic [26:0] got, exp;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) got = {lk0, ls0, pv0, err0, per0};
            else        got = {lk1, ls1, pv1, err1, per1};
            exp = {m_locked[i], m_lost[i], m_pv[i],
                   8'(m_err[i]), 16'(m_per[i])};
            total++;
            assert (got === exp) else begin
                bad++;
                $error("FAIL model dut%0d cyc=%0d got=%h exp=%h",
                       i, cyc, got, exp);
            end
        end
        if (ls0) saw_lost = 1;
        if (pv0 && int'(per0) > pv_max) pv_max = int'(per0);
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic r, input logic m);
        @(negedge clk);
        if (chk_en) check_out();
        rst_n = r;
        mon = m;
        model_step(r, m);
        chk_en = 1;
    endtask

    task automatic clk_period(input int p, input int h);
        for (int i = 0; i < p; i++) tick(1'b1, i < h);
    endtask

    task automatic periods(input int n, input int p, input int h);
        for (int i = 0; i < n; i++) clk_period(p, h);
    endtask

    initial begin
        int p, h;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rst_locked", 32'(lk0), 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst_period", 32'(per0), 0);

        // Lock on a clean period-4 clock.
        periods(12, 4, 2);
        chk("lock_locked", 32'(lk0), 1);
        chk("lock_period", 32'(per0), 4);
        chk("lock_err", 32'(err0), 0);
        chk("lock_no_lost", 32'(saw_lost), 0);

        // Loss of clock.
        for (int i = 0; i < 30; i++) tick(1'b1, 1'b0);
        chk("loss_lost", 32'(ls0), 1);
        chk("loss_locked", 32'(lk0), 0);
        chk("loss_err", 32'(err0), 1);
        periods(12, 4, 2);
        chk("relock_lost", 32'(ls0), 0);
        chk("relock_locked", 32'(lk0), 1);

        // Glitch: one stretched high phase.
        pv_max = 0;
        clk_period(6, 4);
        periods(2, 4, 2);
        chk("glitch_period", 32'(pv_max), 6);
        chk("glitch_locked", 32'(lk0), 0);
        chk("glitch_err", 32'(err0), 2);
        periods(8, 4, 2);
        chk("glitch_relock", 32'(lk0), 1);
        chk("glitch_err2", 32'(err0), 2);

        // Edge on the exact timeout cycle.
        saw_lost = 0;
        pv_max = 0;
        clk_period(16, 2);
        periods(3, 4, 2);
        chk("simul_no_lost", 32'(saw_lost), 0);
        chk("simul_period", 32'(pv_max), 16);
        chk("simul_locked", 32'(lk0), 0);
        chk("simul_err", 32'(err0), 3);
        periods(10, 4, 2);
        chk("simul_relock", 32'(lk0), 1);

        // One-cycle reset while locked.
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        chk("rstmid_locked", 32'(lk0), 0);
        chk("rstmid_err", 32'(err0), 0);
        chk("rstmid_period", 32'(per0), 0);
        chk("rstmid_lost", 32'(ls0), 0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        periods(12, 4, 2);
        chk("rstmid_relock", 32'(lk0), 1);

        // Random periods, including occasional long gaps.
        for (int n = 0; n < 40; n++) begin
            p = ($urandom_range(9, 0) == 0) ? $urandom_range(20, 15)
                                            : $urandom_range(7, 3);
            h = $urandom_range(p - 1, 1);
            clk_period(p, h);
        end

        // Period 5: locks with TOL 1, never with TOL 0.
        tick(1'b0, 1'b0);
        periods(300, 5, 2);
        chk("tol1_locked", 32'(lk1), 1);
        chk("tol0_locked", 32'(lk0), 0);
        chk("tol0_err_sat", 32'(err0), 255);
        periods(3, 5, 2);
        chk("tol0_err_hold", 32'(err0), 255);
        tick(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
